// File: rtl/irq_controller.sv
// irq_controller: memory-mapped edge/level interrupt controller with claim register.
// Optional input synchronizer enabled by defining IRQ_CTRL_SYNC_EN.
module irq_controller #(
  parameter int          NUM_SOURCES = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_i,
  input  logic [31:0]            addr_i,
  input  logic                   read_enable_i,
  output logic [31:0]            read_data_o,
  input  logic [3:0]             write_mask_i,
  input  logic [31:0]            write_data_i,
  output logic                   interrupt_o
);
  localparam int N = NUM_SOURCES;
  logic [N-1:0] sync, hist, edge_pend, enable, trigger;
  logic [N-1:0] pend_eff, active, claim_hot, set_pend, clr_pend, bmask, wbits, trig_next, en_next;
  logic [31:0] byte_mask, rd_next;
  logic [4:0] claim_id;
  logic [1:0] sel;
  logic hit, wr, rd;
  logic unused;
`ifdef IRQ_CTRL_SYNC_EN
  logic [N-1:0] sync_q [SYNC_STAGES];
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign sync = sync_q[SYNC_STAGES-1];
`else
  assign sync = irq_i;
`endif
  assign unused = ^{addr_i[1:0], write_data_i[31:N], byte_mask[31:N]};
  always_comb begin
    byte_mask = {{8{write_mask_i[3]}}, {8{write_mask_i[2]}}, {8{write_mask_i[1]}}, {8{write_mask_i[0]}}};
    bmask     = byte_mask[N-1:0];
    wbits     = write_data_i[N-1:0] & bmask;
    sel       = addr_i[3:2];
    hit       = addr_i[31:4] == BASE_ADDR[31:4];
    wr        = hit && |write_mask_i;
    rd        = hit && read_enable_i;
    pend_eff  = (edge_pend & trigger) | (sync & ~trigger);
    active    = pend_eff & enable;
    // isolate the lowest set bit: fixed priority, lowest index wins
    claim_hot = active & (~active + N'(1));
    claim_id  = '0;
    for (int i = N - 1; i >= 0; i--) if (active[i]) claim_id = 5'(i + 1);
    rd_next   = !rd         ? '0 :
                sel == 2'd0 ? 32'(pend_eff) :
                sel == 2'd1 ? 32'(enable) :
                sel == 2'd2 ? 32'(trigger) : 32'(claim_id);
    en_next   = wr && sel == 2'd1 ? (enable & ~bmask) | wbits : enable;
    trig_next = wr && sel == 2'd2 ? (trigger & ~bmask) | wbits : trigger;
    set_pend  = sync & ~hist;
    clr_pend  = (wr && sel == 2'd0 ? wbits & trigger : '0) |
                (rd && sel == 2'd3 ? claim_hot : '0) |
                (trigger & ~trig_next);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      read_data_o <= '0;
      interrupt_o <= 1'b0;
      edge_pend   <= '0;
      enable      <= '0;
      trigger     <= '0;
      hist        <= '1;
    end else begin
      read_data_o <= rd_next;
      interrupt_o <= |active;
      edge_pend   <= (edge_pend & ~clr_pend) | set_pend;
      enable      <= en_next;
      trigger     <= trig_next;
      hist        <= sync;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table-driven check of irq_controller with a read-data scoreboard.
module tb_irq_controller;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 1'b0;
  logic reset_ni;
  logic [7:0] irq_i;
  logic [31:0] addr_i, read_data_o, write_data_i;
  logic read_enable_i, interrupt_o;
  logic [3:0] write_mask_i;
  typedef struct {
    string name;
    bit rst;
    bit miss;
    logic [3:0] off;
    bit rd;
    logic [3:0] wm;
    logic [31:0] wd;
    logic [7:0] irq;
    logic [31:0] exp_rd;
    bit exp_int;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] sb[$];
  int n_vec = 0;
  int n_err = 0;
  irq_controller dut (
    .clk_i(clk), .reset_ni(reset_ni), .irq_i(irq_i), .addr_i(addr_i),
    .read_enable_i(read_enable_i), .read_data_o(read_data_o),
    .write_mask_i(write_mask_i), .write_data_i(write_data_i), .interrupt_o(interrupt_o)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(string name, bit rst, bit miss, logic [3:0] off, bit rd,
                              logic [3:0] wm, logic [31:0] wd, logic [7:0] irq,
                              logic [31:0] exp_rd, bit exp_int);
    vec_t v;
    v.name = name; v.rst = rst; v.miss = miss; v.off = off; v.rd = rd;
    v.wm = wm; v.wd = wd; v.irq = irq; v.exp_rd = exp_rd; v.exp_int = exp_int;
    return v;
  endfunction
  function automatic void add(string name, bit rst, bit miss, logic [3:0] off, bit rd,
                              logic [3:0] wm, logic [31:0] wd, logic [7:0] irq,
                              logic [31:0] exp_rd, bit exp_int);
    vecs.push_back(mk(name, rst, miss, off, rd, wm, wd, irq, exp_rd, exp_int));
  endfunction
  // exp_rd is the read_data_o due after this cycle's edge; exp_int is interrupt_o after that edge
  task automatic step(input vec_t v);
    logic [31:0] exp;
    reset_ni      = !v.rst;
    addr_i        = BASE + (v.miss ? 32'h10 : 32'h0) + 32'(v.off);
    read_enable_i = v.rd;
    write_mask_i  = v.wm;
    write_data_i  = v.wd;
    irq_i         = v.irq;
    sb.push_back(v.exp_rd);
    @(posedge clk);
    #1;
    n_vec++;
    exp = sb.pop_front();
    if (read_data_o !== exp) begin
      n_err++;
      $display("FAIL %s: read_data_o=%h expected %h", v.name, read_data_o, exp);
    end
    if (interrupt_o !== v.exp_int) begin
      n_err++;
      $display("FAIL %s: interrupt_o=%b expected %b", v.name, interrupt_o, v.exp_int);
    end
  endtask
  initial begin
    //   name               rst miss off  rd wm     wd            irq    exp_rd int
    add("rst_rd0",          1, 0, 4'h0, 1, 4'h0, 32'h0,        8'hFF, 32'h0,  0);
    add("rst_rdC",          1, 0, 4'hC, 1, 4'h0, 32'h0,        8'hFF, 32'h0,  0);
    add("rd_enable0",       0, 0, 4'h4, 1, 4'h0, 32'h0,        8'hFF, 32'h0,  0);
    add("rd_trigger0",      0, 0, 4'h8, 1, 4'h0, 32'h0,        8'hFF, 32'h0,  0);
    add("rd_claim0",        0, 0, 4'hC, 1, 4'h0, 32'h0,        8'hFF, 32'h0,  0);
    add("wr_trig_ff",       0, 0, 4'h8, 0, 4'hF, 32'hFF,       8'hFF, 32'h0,  0);
    add("no_edge_after_rst",0, 0, 4'h0, 1, 4'h0, 32'h0,        8'hFF, 32'h0,  0);
    add("rd_trig_ff",       0, 0, 4'h8, 1, 4'h0, 32'h0,        8'hFF, 32'hFF, 0);
    add("wr_trig_04",       0, 0, 4'h8, 0, 4'hF, 32'h04,       8'h00, 32'h0,  0);
    add("wr_en_04",         0, 0, 4'h4, 0, 4'hF, 32'h04,       8'h00, 32'h0,  0);
    add("pulse2",           0, 0, 4'h0, 0, 4'h0, 32'h0,        8'h04, 32'h0,  0);
    add("pend_04",          0, 0, 4'h0, 1, 4'h0, 32'h0,        8'h00, 32'h04, 1);
    add("claim3",           0, 0, 4'hC, 1, 4'h0, 32'h0,        8'h00, 32'h3,  1);
    add("claim_empty",      0, 0, 4'hC, 1, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    add("wr_trig_lvl",      0, 0, 4'h8, 0, 4'hF, 32'h0,        8'h00, 32'h0,  0);
    add("wr_en_21",         0, 0, 4'h4, 0, 4'hF, 32'h21,       8'h21, 32'h0,  0);
    add("claim1a",          0, 0, 4'hC, 1, 4'h0, 32'h0,        8'h21, 32'h1,  1);
    add("claim1b",          0, 0, 4'hC, 1, 4'h0, 32'h0,        8'h21, 32'h1,  1);
    add("claim6",           0, 0, 4'hC, 1, 4'h0, 32'h0,        8'h20, 32'h6,  1);
    add("lvl_drop",         0, 0, 4'h0, 0, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    add("wr_trig_02",       0, 0, 4'h8, 0, 4'hF, 32'h02,       8'h00, 32'h0,  0);
    add("wr_en_02",         0, 0, 4'h4, 0, 4'hF, 32'h02,       8'h02, 32'h0,  0);
    add("edge1",            0, 0, 4'h0, 0, 4'h0, 32'h0,        8'h00, 32'h0,  1);
    add("w1c_vs_edge",      0, 0, 4'h0, 1, 4'hF, 32'h02,       8'h02, 32'h02, 1);
    add("set_wins",         0, 0, 4'h0, 1, 4'h0, 32'h0,        8'h02, 32'h02, 1);
    add("w1c",              0, 0, 4'h0, 0, 4'hF, 32'h02,       8'h02, 32'h0,  1);
    add("w1c_done",         0, 0, 4'h0, 1, 4'h0, 32'h0,        8'h02, 32'h0,  0);
    add("en_byte1",         0, 0, 4'h4, 0, 4'h2, 32'hFFFF_FFFF, 8'h02, 32'h0,  0);
    add("en_kept",          0, 0, 4'h4, 1, 4'h0, 32'h0,        8'h02, 32'h02, 0);
    add("miss_wr",          0, 1, 4'h8, 0, 4'hF, 32'h0,        8'h02, 32'h0,  0);
    add("miss_rd",          0, 1, 4'h8, 1, 4'h0, 32'h0,        8'h02, 32'h0,  0);
    add("trig_after_miss",  0, 0, 4'h8, 1, 4'h0, 32'h0,        8'h02, 32'h02, 0);
    add("wr_trig_ff2",      0, 0, 4'h8, 0, 4'hF, 32'hFF,       8'h00, 32'h0,  0);
    add("wr_en_ff",         0, 0, 4'h4, 0, 4'hF, 32'hFF,       8'hFF, 32'h0,  0);
    add("pend_ff",          0, 0, 4'h0, 1, 4'h0, 32'h0,        8'hFF, 32'hFF, 1);
    add("rst_mid",          1, 0, 4'h0, 1, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    add("rst_pend",         0, 0, 4'h0, 1, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    add("rst_en",           0, 0, 4'h4, 1, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    add("rst_trig",         0, 0, 4'h8, 1, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    add("rst_claim",        0, 0, 4'hC, 1, 4'h0, 32'h0,        8'h00, 32'h0,  0);
    foreach (vecs[i]) step(vecs[i]);
    // switching a pending edge source to level mode must discard its edge state
    step(mk("h_trig01",   0, 0, 4'h8, 0, 4'hF, 32'h01, 8'h00, 32'h0,  0));
    step(mk("h_en01",     0, 0, 4'h4, 0, 4'hF, 32'h01, 8'h01, 32'h0,  0));
    step(mk("h_pend01",   0, 0, 4'h0, 1, 4'h0, 32'h0,  8'h01, 32'h01, 1));
    step(mk("h_to_level", 0, 0, 4'h8, 0, 4'hF, 32'h00, 8'h01, 32'h0,  1));
    step(mk("h_drop",     0, 0, 4'h0, 0, 4'h0, 32'h0,  8'h00, 32'h0,  0));
    step(mk("h_to_edge",  0, 0, 4'h8, 0, 4'hF, 32'h01, 8'h00, 32'h0,  0));
    step(mk("h_cleared",  0, 0, 4'h0, 1, 4'h0, 32'h0,  8'h00, 32'h0,  0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
